// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the Mini SRC CPU datapath.
// Define CU_MULDIV_EN to execute mul/div; without it opcodes 15/16 retire as nop.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int SELW = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            CON_out,
    output logic            e_PC,
    output logic            incPC,
    output logic            e_IR,
    output logic            e_Y,
    output logic            e_Z,
    output logic            e_HI,
    output logic            e_LO,
    output logic            e_MDR,
    output logic            e_MAR,
    output logic            e_OutPort,
    output logic            e_InPort,
    output logic            e_CON_FF,
    output logic            ram_read,
    output logic            ram_write,
    output logic            MDR_read,
    output logic [3:0]      ALU_op,
    output logic [SELW-1:0] BusDataSelect,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            e_Rin,
    output logic            e_Rout,
    output logic            BAout,
    output logic            imm_sel,
    output logic            run
);

`ifdef CU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
    localparam logic [OPW-1:0] OP_BR   = OPW'(19);
    localparam logic [OPW-1:0] OP_JR   = OPW'(20);
    localparam logic [OPW-1:0] OP_IN   = OPW'(22);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    localparam logic [SELW-1:0] SEL_NONE = SELW'(0);
    localparam logic [SELW-1:0] SEL_HI   = SELW'(16);
    localparam logic [SELW-1:0] SEL_LO   = SELW'(17);
    localparam logic [SELW-1:0] SEL_ZHI  = SELW'(18);
    localparam logic [SELW-1:0] SEL_ZLO  = SELW'(19);
    localparam logic [SELW-1:0] SEL_PC   = SELW'(20);
    localparam logic [SELW-1:0] SEL_MDR  = SELW'(21);
    localparam logic [SELW-1:0] SEL_INP  = SELW'(22);

    localparam logic [3:0] ALU_ADD = 4'd0;

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op;
    logic [3:0]     ra;
    logic [3:0]     rb;
    logic [3:0]     rc;
    logic [2:0]     step;
    logic [2:0]     last_step;
    logic           unused_ir;

    logic is_alu, is_imm, is_unary, is_md, is_ldi, is_ld, is_st, is_br;
    logic is_jr, is_in, is_out, is_mfhi, is_mflo;

    // Per-state micro-op terms, merged into the bus/encoder outputs below
    logic           src_ra, src_rb, src_rc, dst_ra;
    logic [SELW-1:0] fix_sel;

    function automatic logic [3:0] alu_code(input logic [OPW-1:0] o);
        case (int'(o))
            3, 12:   alu_code = 4'd0;
            4:       alu_code = 4'd1;
            5, 13:   alu_code = 4'd2;
            6, 14:   alu_code = 4'd3;
            7:       alu_code = 4'd7;
            8:       alu_code = 4'd8;
            9:       alu_code = 4'd4;
            10:      alu_code = 4'd5;
            11:      alu_code = 4'd6;
            15:      alu_code = 4'd10;
            16:      alu_code = 4'd9;
            17:      alu_code = 4'd11;
            18:      alu_code = 4'd12;
            default: alu_code = 4'd0;
        endcase
    endfunction

    function automatic logic [SELW-1:0] gp_sel(input logic [3:0] f);
        gp_sel = SELW'(f);
    endfunction

    assign op        = IR[31 -: OPW];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];
    assign step      = state_q[2:0];

    assign is_alu   = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_imm   = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_unary = (op == OP_NEG) || (op == OP_NOT);
    assign is_md    = MULDIV && ((op == OP_DIV) || (op == OP_MUL));
    assign is_ldi   = (op == OP_LDI);
    assign is_ld    = (op == OP_LD);
    assign is_st    = (op == OP_ST);
    assign is_br    = (op == OP_BR);
    assign is_jr    = (op == OP_JR);
    assign is_in    = (op == OP_IN);
    assign is_out   = (op == OP_OUT);
    assign is_mfhi  = (op == OP_MFHI);
    assign is_mflo  = (op == OP_MFLO);

    // Final T-step of each instruction class; everything unlisted retires after fetch
    always_comb begin
        last_step = 3'd2;
        if (is_jr || is_in || is_out || is_mfhi || is_mflo) begin
            last_step = 3'd3;
        end else if (is_unary) begin
            last_step = 3'd4;
        end else if (is_alu || is_imm || is_ldi) begin
            last_step = 3'd5;
        end else if (is_md || is_st || is_br) begin
            last_step = 3'd6;
        end else if (is_ld) begin
            last_step = 3'd7;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == HALT) begin
            state_d = HALT;
        end else if ((state_q == T2) && (op == OP_HALT)) begin
            state_d = HALT;
        end else if (step == last_step) begin
            state_d = T0;
        end else begin
            state_d = state_t'(state_q + 4'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; everything idles while clear is low so an aborted write never escapes
    always_comb begin
        e_PC      = 1'b0;
        incPC     = 1'b0;
        e_IR      = 1'b0;
        e_Y       = 1'b0;
        e_Z       = 1'b0;
        e_HI      = 1'b0;
        e_LO      = 1'b0;
        e_MDR     = 1'b0;
        e_MAR     = 1'b0;
        e_OutPort = 1'b0;
        e_InPort  = 1'b0;
        e_CON_FF  = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        MDR_read  = 1'b0;
        ALU_op    = ALU_ADD;
        BAout     = 1'b0;
        imm_sel   = 1'b0;
        src_ra    = 1'b0;
        src_rb    = 1'b0;
        src_rc    = 1'b0;
        dst_ra    = 1'b0;
        fix_sel   = SEL_NONE;
        run       = !(clear && (state_q == HALT));

        if (clear) begin
            case (state_q)
                T0: begin
                    fix_sel = SEL_PC;
                    e_MAR   = 1'b1;
                    incPC   = 1'b1;
                    e_PC    = 1'b1;
                end
                T1: begin
                    ram_read = 1'b1;
                    MDR_read = 1'b1;
                    e_MDR    = 1'b1;
                end
                T2: begin
                    fix_sel = SEL_MDR;
                    e_IR    = 1'b1;
                end
                T3: begin
                    if (is_alu || is_imm) begin
                        src_rb = 1'b1;
                        e_Y    = 1'b1;
                    end else if (is_unary) begin
                        src_rb = 1'b1;
                        ALU_op = alu_code(op);
                        e_Z    = 1'b1;
                    end else if (is_md) begin
                        src_ra = 1'b1;
                        e_Y    = 1'b1;
                    end else if (is_ldi || is_ld || is_st) begin
                        src_rb = 1'b1;
                        BAout  = 1'b1;
                        e_Y    = 1'b1;
                    end else if (is_br) begin
                        src_ra   = 1'b1;
                        e_CON_FF = 1'b1;
                    end else if (is_jr) begin
                        src_ra = 1'b1;
                        e_PC   = 1'b1;
                    end else if (is_in) begin
                        fix_sel = SEL_INP;
                        dst_ra  = 1'b1;
                    end else if (is_out) begin
                        src_ra    = 1'b1;
                        e_OutPort = 1'b1;
                    end else if (is_mfhi) begin
                        fix_sel = SEL_HI;
                        dst_ra  = 1'b1;
                    end else if (is_mflo) begin
                        fix_sel = SEL_LO;
                        dst_ra  = 1'b1;
                    end
                end
                T4: begin
                    if (is_alu) begin
                        src_rc = 1'b1;
                        ALU_op = alu_code(op);
                        e_Z    = 1'b1;
                    end else if (is_imm) begin
                        imm_sel = 1'b1;
                        ALU_op  = alu_code(op);
                        e_Z     = 1'b1;
                    end else if (is_unary) begin
                        fix_sel = SEL_ZLO;
                        dst_ra  = 1'b1;
                    end else if (is_md) begin
                        src_rb = 1'b1;
                        ALU_op = alu_code(op);
                        e_Z    = 1'b1;
                    end else if (is_ldi || is_ld || is_st) begin
                        imm_sel = 1'b1;
                        ALU_op  = ALU_ADD;
                        e_Z     = 1'b1;
                    end else if (is_br) begin
                        fix_sel = SEL_PC;
                        e_Y     = 1'b1;
                    end
                end
                T5: begin
                    if (is_alu || is_imm || is_ldi) begin
                        fix_sel = SEL_ZLO;
                        dst_ra  = 1'b1;
                    end else if (is_md) begin
                        fix_sel = SEL_ZLO;
                        e_LO    = 1'b1;
                    end else if (is_ld || is_st) begin
                        fix_sel = SEL_ZLO;
                        e_MAR   = 1'b1;
                    end else if (is_br) begin
                        imm_sel = 1'b1;
                        ALU_op  = ALU_ADD;
                        e_Z     = 1'b1;
                    end
                end
                T6: begin
                    if (is_md) begin
                        fix_sel = SEL_ZHI;
                        e_HI    = 1'b1;
                    end else if (is_ld) begin
                        ram_read = 1'b1;
                        MDR_read = 1'b1;
                        e_MDR    = 1'b1;
                    end else if (is_st) begin
                        src_ra    = 1'b1;
                        ram_write = 1'b1;
                    end else if (is_br) begin
                        fix_sel = SEL_ZLO;
                        e_PC    = CON_out;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        fix_sel = SEL_MDR;
                        dst_ra  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A GP register on the bus is encoded from its IR field with Rout and the matching Gr*
    always_comb begin
        Gra    = src_ra | dst_ra;
        Grb    = src_rb;
        Grc    = src_rc;
        e_Rin  = dst_ra;
        e_Rout = src_ra | src_rb | src_rc;
        if (src_ra) begin
            BusDataSelect = gp_sel(ra);
        end else if (src_rb) begin
            BusDataSelect = gp_sel(rb);
        end else if (src_rc) begin
            BusDataSelect = gp_sel(rc);
        end else begin
            BusDataSelect = fix_sel;
        end
    end

endmodule
